// File: rtl/seq_restoring_div.sv
// Sequential unsigned restoring divider. It produces one quotient bit per clock and
// uses a start/done handshake to sit beside the accumulator ALU.
// Each iteration builds the trial difference with the conditional-subtract datapath:
// the divisor is inverted and added with a carry-in of 1. The carry-out is the
// "no borrow" flag.
module seq_restoring_div #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e state_q, state_d;

    // Working registers: q_q shifts the dividend out and the quotient in.
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    // zero_q marks the single pass through StRun taken for a zero divisor.
    // No iteration happens during that pass, so busy stays low.
    logic             zero_q, zero_d;

    // Result registers. They hold until a new result overwrites them.
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dz_q, dz_d;

    // Datapath signals.
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   sub_b;
    logic [WIDTH:0]   diff;
    logic             no_borrow;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;
    logic             unused_diff_msb;
    logic             accept;

    // Trial subtract. The shifted partial remainder is WIDTH+1 bits wide, so the bit
    // shifted out of R is kept. The result is shifted - D.
    always_comb begin
        shifted         = {r_q, q_q[WIDTH-1]};
        sub_b           = ~{1'b0, d_q};
        {no_borrow, diff} = {1'b0, shifted} + {1'b0, sub_b} + {{(WIDTH + 1){1'b0}}, 1'b1};
        // When no borrow occurs, diff < D and fits in WIDTH bits, so its MSB is always 0.
        unused_diff_msb = diff[WIDTH];
        r_next          = no_borrow ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        q_next          = {q_q[WIDTH-2:0], no_borrow};
    end

    assign accept = start && ((state_q == StIdle) || (state_q == StDone));

    // Next-state logic: start acceptance, iteration and result write-back.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        d_d     = d_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        zero_d  = zero_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dz_d    = dz_q;

        case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (accept) begin
                    q_d     = dividend;
                    d_d     = divisor;
                    r_d     = '0;
                    cnt_d   = '0;
                    zero_d  = (divisor == '0);
                    state_d = StRun;
                end
            end
            StRun: begin
                if (zero_q) begin
                    // Divide by zero: all-ones quotient, dividend returned as remainder.
                    state_d = StDone;
                    zero_d  = 1'b0;
                    quot_d  = '1;
                    rem_d   = q_q;
                    dz_d    = 1'b1;
                end else begin
                    q_d   = q_next;
                    r_d   = r_next;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = StDone;
                        quot_d  = q_next;
                        rem_d   = r_next;
                        dz_d    = 1'b0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers. Reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            q_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            d_q     <= d_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            zero_q  <= zero_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
        end
    end

    // Outputs. done is only high in StDone and busy only in StRun, so they never overlap.
    always_comb begin
        busy        = (state_q == StRun) && !zero_q;
        done        = (state_q == StDone);
        quotient    = quot_q;
        remainder   = rem_q;
        div_by_zero = dz_q;
    end

endmodule
